// File: rtl/clk_div_sel_arbiter_pkg.sv
// Shared definitions for the divider-select arbiter: select codes, FSM
// state encoding and select canonicalization.
package clk_div_pkg;

  localparam logic [2:0] SEL_DIV2   = 3'b000;
  localparam logic [2:0] SEL_DIV4   = 3'b001;
  localparam logic [2:0] SEL_DIV8   = 3'b010;
  localparam logic [2:0] SEL_DIV16  = 3'b011;
  localparam logic [2:0] SEL_BYPASS = 3'b100;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_ACK    = 2'd2;

  // Every 1xx code selects the undivided clock; fold them onto one code.
  function automatic logic [2:0] canon_sel(input logic [2:0] sel);
    return sel[2] ? SEL_BYPASS : sel;
  endfunction

endpackage

// File: rtl/clk_div_sel_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above
// i_ptr, wrapping around to index 0.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [IW-1:0]      o_winner,
  output logic               o_valid
);

  always_comb begin
    int unsigned idx;
    idx      = 0;
    o_winner = '0;
    o_valid  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(i_ptr) + i) % NUM_REQ;
      if (!o_valid && i_req[idx]) begin
        o_valid  = 1'b1;
        o_winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/clk_div_sel_arbiter.sv
// Arbitrates divider-rate requests, drives the divider select and holds off
// the acknowledge until the glitch-free mux has settled on the new rate.
module clk_div_sel_arbiter
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SETTLE_CYCLES = 32,
  parameter logic [2:0]  RESET_SEL     = 3'b000
) (
  input  logic                   i_clk,
  input  logic                   i_resetn,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [3*NUM_REQ-1:0]   i_req_sel,
  output logic [2:0]             o_sel,
  output logic [NUM_REQ-1:0]     o_ack,
  output logic                   o_busy
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [IW-1:0] ptr_q,   ptr_d;
  logic [IW-1:0] win_q,   win_d;
  logic [2:0]    lsel_q,  lsel_d;
  logic [2:0]    sel_q,   sel_d;

  logic [IW-1:0] arb_win;
  logic          arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req    (i_req),
    .i_ptr    (ptr_q),
    .o_winner (arb_win),
    .o_valid  (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    lsel_d  = lsel_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          win_d  = arb_win;
          lsel_d = canon_sel(i_req_sel[3*arb_win +: 3]);
          ptr_d  = (arb_win == IW'(NUM_REQ - 1)) ? '0 : arb_win + IW'(1);
          // Same rate already live: skip the settle window entirely.
          if (lsel_d != sel_q) begin
            sel_d   = lsel_d;
            cnt_d   = CW'(SETTLE_CYCLES - 1);
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_ACK;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      lsel_q  <= RESET_SEL;
      sel_q   <= RESET_SEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      lsel_q  <= lsel_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    o_ack = '0;
    if (state_q == ST_ACK) o_ack[win_q] = 1'b1;
  end

  assign o_sel  = sel_q;
  assign o_busy = (state_q != ST_IDLE);

endmodule
